// File: rtl/cnt12_ctrl_if.sv
// Link between the run controller and the mod-12 counter datapath.
interface cnt12_ctrl_if;
    logic       tick;    // counter sample strobe
    logic       carry;   // counter holds its terminal value
    logic       en;      // counter enable
    logic       mode;    // 1 = up, 0 = down
    logic       load;    // load request
    logic [3:0] preset;  // value loaded on a load request

    modport master (
        input  tick,
        input  carry,
        output en,
        output mode,
        output load,
        output preset
    );

    modport slave (
        output tick,
        output carry,
        input  en,
        input  mode,
        input  load,
        input  preset
    );
endinterface

// File: rtl/cnt12_ctrl.sv
// Button-driven run/pause/load controller for the mod-12 counter.
// Four debounced keys drive the FSM and the direction / one-shot toggles.
module cnt12_ctrl #(
    parameter int unsigned DEB_W   = 20,
    parameter int unsigned DEB_MAX = 999_999
) (
    input  logic               clk,
    input  logic               rst,
    cnt12_ctrl_if.master       bus,
    input  logic               key_run,
    input  logic               key_load,
    input  logic               key_dir,
    input  logic               key_shot,
    input  logic [3:0]         sw_preset,
    output logic               shot,
    output logic               done,
    output logic [1:0]         state
);

    localparam int unsigned N_KEYS   = 4;
    localparam int unsigned KEY_RUN  = 0;
    localparam int unsigned KEY_LOAD = 1;
    localparam int unsigned KEY_DIR  = 2;
    localparam int unsigned KEY_SHOT = 3;
    localparam logic [3:0]  TERM_VAL = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LOAD  = 2'b11
    } state_t;

    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] press;
    logic [DEB_W-1:0]  deb_cnt [N_KEYS];

    state_t     state_q;
    logic       mode_q;
    logic       load_q;
    logic [3:0] preset_q;
    logic       moved;
    logic       run_en;
    logic [3:0] preset_clamped;

    assign key_raw = {key_shot, key_dir, key_load, key_run};

    // Synchronize, debounce, and emit a one-clk press on each accepted rising level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int i = 0; i < N_KEYS; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_MAX)) begin
                    level[i]   <= sync2[i];
                    deb_cnt[i] <= '0;
                    press[i]   <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Enable drops the moment a one-shot lap lands on the terminal value,
    // so the counter never sees the wrapping tick.
    assign run_en = (state_q == S_RUN) && !(shot && moved && bus.carry);

    assign preset_clamped = (sw_preset > TERM_VAL) ? TERM_VAL : sw_preset;

    // Run/pause/load FSM plus the FSM-independent direction and one-shot toggles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b1;
            load_q   <= 1'b0;
            preset_q <= '0;
            shot     <= 1'b0;
            done     <= 1'b0;
            moved    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (press[KEY_DIR]) begin
                mode_q <= ~mode_q;
            end
            if (press[KEY_SHOT]) begin
                shot <= ~shot;
            end
            if (run_en && bus.tick) begin
                moved <= 1'b1;
            end
            case (state_q)
                S_IDLE, S_PAUSE: begin
                    if (press[KEY_LOAD]) begin
                        state_q  <= S_LOAD;
                        load_q   <= 1'b1;
                        preset_q <= preset_clamped;
                    end else if (press[KEY_RUN]) begin
                        state_q <= S_RUN;
                        moved   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (press[KEY_LOAD]) begin
                        state_q  <= S_LOAD;
                        load_q   <= 1'b1;
                        preset_q <= preset_clamped;
                    end else if (press[KEY_RUN]) begin
                        state_q <= S_PAUSE;
                    end else if (shot && moved && bus.carry) begin
                        state_q <= S_IDLE;
                        done    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // Key presses are dropped here; hold load until the counter samples it.
                    if (bus.tick) begin
                        load_q  <= 1'b0;
                        state_q <= S_PAUSE;
                    end
                end
            endcase
        end
    end

    assign bus.en     = run_en;
    assign bus.mode   = mode_q;
    assign bus.load   = load_q;
    assign bus.preset = preset_q;
    assign state      = state_q;

endmodule

// File: tb/tb_cnt12_ctrl.sv
// Directed bench for cnt12_ctrl with a small mod-12 counter model on the link.
module tb_cnt12_ctrl;

    localparam int unsigned DEB_W   = 20;
    localparam int unsigned DEB_MAX = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keys = 4'd0;        // {shot, dir, load, run}
    logic [3:0] sw_preset = 4'd0;
    logic       shot;
    logic       done;
    logic [1:0] state;

    logic       tick = 1'b0;
    int unsigned tick_ph = 0;
    logic [3:0] cnt = 4'd0;

    int passed = 0;
    int total  = 0;

    cnt12_ctrl_if bus();

    cnt12_ctrl #(.DEB_W(DEB_W), .DEB_MAX(DEB_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .key_run   (keys[0]),
        .key_load  (keys[1]),
        .key_dir   (keys[2]),
        .key_shot  (keys[3]),
        .sw_preset (sw_preset),
        .shot      (shot),
        .done      (done),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Tick once every 8 clks.
    always @(posedge clk) begin
        tick_ph <= (tick_ph == 7) ? 0 : tick_ph + 1;
        tick    <= (tick_ph == 7);
    end

    // Mod-12 counter datapath model.
    always @(posedge clk) begin
        if (tick) begin
            if (bus.load)
                cnt <= bus.preset;
            else if (bus.en)
                cnt <= bus.mode ? ((cnt == 4'd11) ? 4'd0 : cnt + 4'd1)
                                : ((cnt == 4'd0) ? 4'd11 : cnt - 4'd1);
        end
    end

    assign bus.tick  = tick;
    assign bus.carry = bus.mode ? (cnt == 4'd11) : (cnt == 4'd0);

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the keys long enough for a press, then release and let them settle.
    task automatic press_keys(input logic [3:0] m);
        keys = m;
        step(8);
        keys = 4'd0;
        step(8);
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        keys = 4'd0;
        step(3);
        rst = 1'b0;
        step(1);
        total++; if (state !== 2'd0)    $display("FAIL reset_state: got %0d expected 0", state);     else passed++;
        total++; if (bus.en !== 1'b0)   $display("FAIL reset_en: got %0b expected 0", bus.en);       else passed++;
        total++; if (bus.mode !== 1'b1) $display("FAIL reset_mode: got %0b expected 1", bus.mode);   else passed++;
        total++; if (bus.load !== 1'b0) $display("FAIL reset_load: got %0b expected 0", bus.load);   else passed++;
        total++; if (bus.preset !== 4'd0) $display("FAIL reset_preset: got %0d expected 0", bus.preset); else passed++;
        total++; if (shot !== 1'b0)     $display("FAIL reset_shot: got %0b expected 0", shot);       else passed++;
        total++; if (done !== 1'b0)     $display("FAIL reset_done: got %0b expected 0", done);       else passed++;
    endtask

    task automatic test_run_press;
        keys = 4'b0001;
        step(7);
        total++; if (state !== 2'd0) $display("FAIL run_latency_early: got %0d expected 0", state); else passed++;
        step(1);
        total++; if (state !== 2'd1)  $display("FAIL run_state: got %0d expected 1", state);   else passed++;
        total++; if (bus.en !== 1'b1) $display("FAIL run_en: got %0b expected 1", bus.en);     else passed++;
        keys = 4'd0;
        step(8);
        press_keys(4'b0001);
        total++; if (state !== 2'd2)  $display("FAIL pause_state: got %0d expected 2", state); else passed++;
        total++; if (bus.en !== 1'b0) $display("FAIL pause_en: got %0b expected 0", bus.en);   else passed++;
    endtask

    task automatic test_bounce;
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            keys[0] = ~keys[0];
            step(2);
            if (state !== 2'd2) bad++;
        end
        total++; if (bad != 0) $display("FAIL bounce_no_change: got %0d bad cycles expected 0", bad); else passed++;
        keys[0] = 1'b1;
        step(8);
        total++; if (state !== 2'd1) $display("FAIL bounce_settle: got %0d expected 1", state); else passed++;
        keys[0] = 1'b0;
        step(16);
        total++; if (state !== 2'd1) $display("FAIL bounce_single_press: got %0d expected 1", state); else passed++;
        press_keys(4'b0001);
        total++; if (state !== 2'd2) $display("FAIL bounce_repause: got %0d expected 2", state); else passed++;
    endtask

    task automatic test_load;
        bit ok;
        sw_preset = 4'd14;
        wait_tick(ok);
        total++; if (!ok) $display("FAIL load_tick_wait: got no tick expected tick within 16 clks"); else passed++;
        step(1);
        keys[1] = 1'b1;
        step(2);
        keys[0] = 1'b1;
        step(6);
        total++; if (state !== 2'd3)     $display("FAIL load_entry_state: got %0d expected 3", state);      else passed++;
        total++; if (bus.preset !== 4'd11) $display("FAIL load_clamp: got %0d expected 11", bus.preset);    else passed++;
        total++; if (bus.load !== 1'b1)  $display("FAIL load_entry_load: got %0b expected 1", bus.load);    else passed++;
        keys = 4'd0;
        step(2);
        total++; if (state !== 2'd3)     $display("FAIL load_run_ignored: got %0d expected 3", state);      else passed++;
        step(5);
        total++; if (state !== 2'd3 || bus.load !== 1'b1)
            $display("FAIL load_tick_cycle: got state %0d load %0b expected 3/1", state, bus.load); else passed++;
        step(1);
        total++; if (state !== 2'd2)     $display("FAIL load_exit_state: got %0d expected 2", state);       else passed++;
        total++; if (bus.load !== 1'b0)  $display("FAIL load_exit_load: got %0b expected 0", bus.load);     else passed++;
        step(10);
        total++; if (state !== 2'd2)     $display("FAIL load_stay_pause: got %0d expected 2", state);       else passed++;
    endtask

    task automatic test_load_short;
        bit ok;
        sw_preset = 4'd5;
        wait_tick(ok);
        total++; if (!ok) $display("FAIL short_tick_wait: got no tick expected tick within 16 clks"); else passed++;
        keys[1] = 1'b1;
        step(8);
        total++; if (state !== 2'd3 || bus.load !== 1'b1 || bus.preset !== 4'd5)
            $display("FAIL short_entry: got state %0d load %0b preset %0d expected 3/1/5", state, bus.load, bus.preset); else passed++;
        step(1);
        total++; if (state !== 2'd2 || bus.load !== 1'b0)
            $display("FAIL short_exit: got state %0d load %0b expected 2/0", state, bus.load); else passed++;
        keys = 4'd0;
        step(10);
    endtask

    task automatic test_simultaneous;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        keys = 4'b0011;
        step(8);
        total++; if (state !== 2'd3)    $display("FAIL simul_load_wins: got %0d expected 3", state);  else passed++;
        total++; if (bus.load !== 1'b1) $display("FAIL simul_load: got %0b expected 1", bus.load);     else passed++;
        keys = 4'd0;
        step(16);
        total++; if (state !== 2'd2)    $display("FAIL simul_after: got %0d expected 2", state);       else passed++;
    endtask

    task automatic test_oneshot;
        int  ticks;
        int  en_bad;
        bit  left;
        bit  exited;
        press_keys(4'b1000);
        total++; if (shot !== 1'b1) $display("FAIL shot_toggle: got %0b expected 1", shot); else passed++;
        sw_preset = 4'd11;
        keys = 4'b0010;
        step(8);
        keys = 4'd0;
        step(16);
        total++; if (state !== 2'd2) $display("FAIL shot_preload: got %0d expected 2", state); else passed++;
        keys = 4'b0001;
        step(8);
        keys = 4'd0;
        total++; if (state !== 2'd1 || bus.en !== 1'b1)
            $display("FAIL shot_start: got state %0d en %0b expected 1/1", state, bus.en); else passed++;
        ticks = 0; en_bad = 0; left = 1'b0; exited = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (state === 2'd1) begin
                if (cnt != 4'd11) left = 1'b1;
                if (left && cnt == 4'd11) begin
                    total++; if (bus.en !== 1'b0) $display("FAIL shot_freeze_en: got %0b expected 0", bus.en); else passed++;
                    step(1);
                    total++; if (state !== 2'd0 || done !== 1'b1)
                        $display("FAIL shot_exit: got state %0d done %0b expected 0/1", state, done); else passed++;
                    step(1);
                    total++; if (done !== 1'b0) $display("FAIL shot_done_width: got %0b expected 0", done); else passed++;
                    exited = 1'b1;
                    break;
                end else begin
                    if (bus.en !== 1'b1) en_bad++;
                    if (tick && bus.en === 1'b1) ticks++;
                end
            end else begin
                en_bad++;
            end
            step(1);
        end
        total++; if (!exited)  $display("FAIL shot_timeout: got no exit expected exit within 200 clks"); else passed++;
        total++; if (ticks != 12) $display("FAIL shot_lap_ticks: got %0d expected 12", ticks);            else passed++;
        total++; if (en_bad != 0) $display("FAIL shot_en_held: got %0d bad cycles expected 0", en_bad);    else passed++;
    endtask

    task automatic test_reset_mid;
        press_keys(4'b0100);
        total++; if (bus.mode !== 1'b0) $display("FAIL dir_toggle: got %0b expected 0", bus.mode); else passed++;
        keys = 4'b0010;
        step(8);
        total++; if (state !== 2'd3) $display("FAIL midload_entry: got %0d expected 3", state); else passed++;
        rst = 1'b1;
        keys = 4'd0;
        step(1);
        total++; if (state !== 2'd0 || bus.load !== 1'b0 || bus.preset !== 4'd0 || bus.mode !== 1'b1 ||
                     shot !== 1'b0 || bus.en !== 1'b0 || done !== 1'b0)
            $display("FAIL midload_reset: got st%0d ld%0b pr%0d md%0b sh%0b en%0b dn%0b expected 0/0/0/1/0/0/0",
                     state, bus.load, bus.preset, bus.mode, shot, bus.en, done); else passed++;
        rst = 1'b0;
        step(1);
        press_keys(4'b1100);
        total++; if (shot !== 1'b1 || bus.mode !== 1'b0)
            $display("FAIL midrun_setup: got shot %0b mode %0b expected 1/0", shot, bus.mode); else passed++;
        keys = 4'b0001;
        step(8);
        total++; if (state !== 2'd1) $display("FAIL midrun_entry: got %0d expected 1", state); else passed++;
        rst = 1'b1;
        keys = 4'd0;
        step(1);
        total++; if (state !== 2'd0 || bus.load !== 1'b0 || bus.preset !== 4'd0 || bus.mode !== 1'b1 ||
                     shot !== 1'b0 || bus.en !== 1'b0 || done !== 1'b0)
            $display("FAIL midrun_reset: got st%0d ld%0b pr%0d md%0b sh%0b en%0b dn%0b expected 0/0/0/1/0/0/0",
                     state, bus.load, bus.preset, bus.mode, shot, bus.en, done); else passed++;
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_run_press();
        test_bounce();
        test_load();
        test_load_short();
        test_simultaneous();
        test_oneshot();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cnt12_ctrl.md
# cnt12_ctrl

Button-driven run controller for the mod-12 counter datapath. It debounces four push-keys and runs a run/pause/load state machine. It drives the counter's enable, count direction, preset value and load request, and supports a one-shot mode that halts the count at the terminal value. It runs on the fast board clock, next to the clock divider, and aligns its load request to the divider's sample strobe.

## Interface
Parameters:
- DEB_W, 20, width of each debounce counter.
- DEB_MAX, 999_999, consecutive stable cycles needed to accept a key level (20 ms at 50 MHz).

Ports:
- clk  in  1  board clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-clk strobe; the counter samples en/mode/load/preset on this cycle.
- carry  in  1  counter holds its terminal value (11 when counting up, 0 when counting down); level, combinational from the datapath.
- key_run  in  1  raw run/pause key, active-high.
- key_load  in  1  raw load key, active-high.
- key_dir  in  1  raw direction-toggle key, active-high.
- key_shot  in  1  raw one-shot-toggle key, active-high.
- sw_preset  in  4  preset switches.
- en  out  1  counter enable (combinational, see Operation).
- mode  out  1  direction; 1 = up, 0 = down.
- load  out  1  load request to the counter.
- preset  out  4  latched, clamped preset value.
- shot  out  1  one-shot mode active.
- done  out  1  one-clk pulse when a one-shot run completes.
- state  out  2  FSM state, for debug LEDs.

## Operation
- Per key:
  - 2-FF synchronizer, then a debounce counter.
  - The counter increments while the synced level differs from the accepted level, and clears otherwise.
  - At DEB_MAX the accepted level flips and the counter clears.
  - A press pulse (one clk) fires on each rising edge of the accepted level.
- FSM states: IDLE=00, RUN=01, PAUSE=10, LOAD=11.
- IDLE:
  - run press → RUN.
  - load press → LOAD.
- RUN:
  - run press → PAUSE.
  - load press → LOAD.
  - shot=1 and moved=1 and carry=1 → IDLE, with done pulsed on that transition.
- PAUSE:
  - run press → RUN.
  - load press → LOAD.
- LOAD:
  - preset is latched on entry as min(sw_preset, 11).
  - load=1 from entry until the first cycle with tick=1 (inclusive), then → PAUSE.
  - run and load presses arriving in LOAD are discarded.
- A run press and a load press in the same cycle: load wins.
- moved flag:
  - cleared on any entry to RUN.
  - set on a cycle with state=RUN, en=1 and tick=1.
  - Purpose: a one-shot run started at the terminal value counts a full lap instead of stopping immediately.
- en = (state==RUN) && !(shot && moved && carry). This freezes the counter on the terminal value before the wrapping tick.
- dir press toggles mode in any state.
- shot press toggles shot in any state.
- The direction and one-shot toggles are independent of the FSM and can coincide with FSM presses.

## Timing
- Reset values: state=IDLE, en=0, mode=1, load=0, preset=0, shot=0, done=0, moved=0. All debounce counters and accepted levels are 0.
- rst is synchronous: a reset asserted mid-LOAD drops load on the next clk edge, regardless of tick.
- Key latency:
  - The raw level must be stable for 2 + DEB_MAX cycles before the press pulse.
  - The FSM changes state on the clk edge after the press pulse.
- All outputs except en are registered.
- en follows state/carry combinationally with no extra cycle.
- load width: from 1 clk (tick already high on the entry cycle) up to one full tick period.
- done is high for exactly one clk, on the cycle after the RUN→IDLE one-shot exit.
- Key bounce shorter than DEB_MAX cycles never produces a press; release produces no press.

## Test plan
DEB_MAX=4 in simulation; tick every 8 clks.
- Reset, then one run press → press pulse 7 clks after the raw rise (2 sync + 4 stable + 1). state=01 and en=1 one clk later; after a second press, state=10 and en=0.
- Bouncing key_run (toggle every 2 clks for 20 clks, then settle high) → exactly one press pulse; no state change during the bounce.
- sw_preset=14, load press from PAUSE:
  - preset=11.
  - load high from entry through the next tick cycle, then load=0 and state=PAUSE.
  - A run press during LOAD is ignored.
- run and load presses in the same clk from IDLE → state=LOAD, not RUN.
- shot=1, mode=up, counter preset 11 (carry=1), run:
  - en stays 1 through a full lap (moved gating).
  - On the return to 11: en=0 combinationally, state=IDLE next clk, done pulses once.
- rst asserted mid-LOAD and mid-RUN with shot=1, mode=0 → all outputs return to their reset values on the next clk.
